dcache_wb: RTL and testbench
============================

Name: dcache_wb

Overview:
- Parametrised write-back, write-allocate, set-associative data cache.
- Sits between the MEM stage word port (the *_2DC/*_fDC signals) and the data-memory block port (dBlkRead/dBlkWrite, 256-bit blocks).
- Replaces the current pass-through wiring, where data_valid_fDC is tied to 1.
- Provides the flush-and-invalidate sequence that SYS requires before a syscall.

Parameters:
- SETS, 8, number of sets; power of two, 2..256.
- WAYS, 2, associativity; 1..4.
- Fixed geometry: block size is 32 bytes (256 bits), i.e. 8 words.
- Address split:
  - offset = addr[4:0]; word index = addr[4:2].
  - index = addr[5+log2(SETS)-1:5].
  - tag = remaining upper bits.

Ports:
- CLK  in  1  clock
- RESET  in  1  asynchronous, active-low reset
- data_address_2DC  in  32  byte address of CPU access
- read_2DC  in  1  CPU read request (level, held until data_valid_fDC)
- write_2DC  in  1  CPU write request (level, held until data_valid_fDC)
- data_write_2DC  in  32  write data, right-aligned
- data_write_size_2DC  in  2  bytes to write: 1, 2, 3; 0 means 4
- flush_2DC  in  1  flush request (level, held until flush_done)
- data_read_fDC  out  32  aligned word at addr[31:2]
- data_valid_fDC  out  1  access complete this cycle
- flush_done  out  1  one-cycle pulse when flush finished
- data_address_2DM  out  32  block address (low 5 bits zero)
- dBlkRead  out  1  block read request
- dBlkWrite  out  1  block write request
- block_write_2DM  out  256  victim block data
- block_read_fDM  in  256  refill data
- block_read_fDM_valid  in  1  refill data valid
- block_write_fDM_valid  in  1  block write accepted

Behaviour:
- Reset (RESET low, asynchronous):
  - FSM returns to IDLE; all valid and dirty bits clear; round-robin pointers = 0.
  - Outputs are 0: dBlkRead, dBlkWrite, data_valid_fDC, flush_done, data_address_2DM, data_read_fDC.
  - The data and tag arrays are not reset.
  - Reset mid-operation abandons the transfer immediately; no partial install.
- Block layout: word i occupies block bits [32i+31:32i].
- FSM states: IDLE, WRITEBACK, REFILL, FLUSH_SCAN, FLUSH_WB, FLUSH_DONE.
- IDLE, request arbitration:
  - Priority: flush_2DC > write_2DC > read_2DC.
  - Read and write asserted together are treated as a write.
- IDLE, hit (combinational lookup):
  - data_valid_fDC = 1 in the same cycle; latency 0.
  - Read: data_read_fDC = the selected word.
  - Write: bytes merge at the clock edge and dirty is set.
- Write merge (big-endian):
  - Size N takes data_write_2DC[8N-1:0]; its MSB byte goes to byte offset addr[1:0].
  - Bytes falling beyond the word boundary are dropped.
  - Example: size 2 at offset 2 writes word bits [15:0].
- IDLE, miss:
  - data_valid_fDC = 0.
  - Victim = lowest-index invalid way; otherwise the set's round-robin pointer.
  - Victim dirty -> WRITEBACK; else -> REFILL.
- WRITEBACK:
  - dBlkWrite = 1; data_address_2DM = {victim tag, index, 5'b0}; block_write_2DM = victim data.
  - All held stable until block_write_fDM_valid.
  - Then clear dirty and go to REFILL.
- REFILL:
  - dBlkRead = 1; data_address_2DM = {request addr[31:5], 5'b0}.
  - On block_read_fDM_valid: install block, tag, valid=1, dirty=0; advance the set pointer (mod WAYS); go to IDLE.
  - The request then hits in the next cycle, so the miss completes one cycle after the refill valid.
- Flush:
  - FLUSH_SCAN walks (set, way) from 0 to SETS*WAYS-1, one line per cycle.
  - Dirty line -> FLUSH_WB, same handshake as WRITEBACK; then resume the scan at the next line.
  - Every line is invalidated.
  - After the last line -> FLUSH_DONE: flush_done = 1 for one cycle, then IDLE.
  - A flush with no dirty lines takes SETS*WAYS+1 cycles.
- dBlkRead and dBlkWrite are never both 1.
- Memory-side valid inputs are ignored outside their matching state.
- data_valid_fDC is 0 in every state except IDLE-hit.
- Dirty data is never lost: a dirty line is always written back before it is replaced or invalidated.

Decomposition:
- dcache_pkg holds:
  - the state enum;
  - BLOCK_BITS=256, WORD_BITS=32, OFFSET_BITS=5;
  - a byte-merge function (size, offset, data -> merged word).
- One sub-module, dcache_way: tag, valid and dirty storage plus the data array for one way, with a single write port (word-merge or full-block install).
- The top level instantiates WAYS copies of dcache_way and holds the FSM, victim selection and round-robin pointers.

Test Plan (SETS=4, WAYS=2, memory answers 3 cycles after a request):
- Cold read 0x00001004:
  - dBlkRead with data_address_2DM=0x00001000; no dBlkWrite.
  - Memory returns word1=0xDEADBEEF; next cycle data_valid_fDC=1 and data_read_fDC=0xDEADBEEF.
- Byte and halfword writes on that line (hit, valid the same cycle, no memory traffic):
  - Write 0x00001005, size 1, data 0x000000AB -> read returns 0xDEABBEEF.
  - Write 0x00001006, size 2, data 0x00001234 -> read returns 0xDEAB1234.
- Eviction:
  - Dirty 0x1000, then read 0x1080 (fills way1), then read 0x1100.
  - Expect dBlkWrite at 0x00001000 carrying 0xDEAB1234 in word1, then dBlkRead at 0x00001100; the set pointer advances.
- Flush with two dirty lines:
  - Exactly two dBlkWrite handshakes, then a single flush_done pulse.
  - A following read of 0x1004 misses (dBlkRead asserted).
- Reset mid-refill: drive RESET low while dBlkRead=1:
  - dBlkRead falls asynchronously.
  - After release, a read of 0x1000 misses.
- Simultaneous requests:
  - flush_2DC with read_2DC: the flush completes first, then the read is serviced.
  - read_2DC with write_2DC: only the write is performed.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared geometry, FSM state codes and the big-endian byte-merge helper
// for the write-back data cache.
package dcache_pkg;

  localparam int BLOCK_BITS  = 256;
  localparam int WORD_BITS   = 32;
  localparam int OFFSET_BITS = 5;

  localparam logic [2:0] S_IDLE       = 3'd0;
  localparam logic [2:0] S_WRITEBACK  = 3'd1;
  localparam logic [2:0] S_REFILL     = 3'd2;
  localparam logic [2:0] S_FLUSH_SCAN = 3'd3;
  localparam logic [2:0] S_FLUSH_WB   = 3'd4;
  localparam logic [2:0] S_FLUSH_DONE = 3'd5;

  // Size N (0 = 4) takes wdata[8N-1:0]; its MSB byte lands at byte offset
  // 'offset' (byte 0 = bits [31:24]); bytes past the word end are dropped.
  function automatic logic [WORD_BITS-1:0] byte_merge(
    input logic [WORD_BITS-1:0] old_word,
    input logic [1:0]           size,
    input logic [1:0]           offset,
    input logic [WORD_BITS-1:0] wdata
  );
    logic [WORD_BITS-1:0] r;
    int n;
    int pos;
    r = old_word;
    n = (size == 2'd0) ? 4 : int'(size);
    for (int j = 0; j < 4; j++) begin
      pos = int'(offset) + j;
      if (j < n && pos < 4) r[31-8*pos -: 8] = wdata[8*(n-1-j) +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/dcache_way.sv
// One cache way: tag/valid/dirty plus block data, single write port
// (word merge or full block install), read at the same index.
module dcache_way
  import dcache_pkg::*;
#(
  parameter int SETS     = 8,
  parameter int IDX_BITS = 3,
  parameter int TAG_BITS = 24
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [IDX_BITS-1:0]   idx,
  input  logic                  word_we,
  input  logic [2:0]            word_sel,
  input  logic [WORD_BITS-1:0]  word_data,
  input  logic                  fill_we,
  input  logic [TAG_BITS-1:0]   fill_tag,
  input  logic [BLOCK_BITS-1:0] fill_data,
  input  logic                  clean,
  input  logic                  inval,
  output logic [TAG_BITS-1:0]   tag,
  output logic                  valid,
  output logic                  dirty,
  output logic [BLOCK_BITS-1:0] data
);

  logic [SETS-1:0]       valid_q;
  logic [SETS-1:0]       dirty_q;
  logic [TAG_BITS-1:0]   tag_q  [SETS];
  logic [BLOCK_BITS-1:0] data_q [SETS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (inval) begin
      valid_q[idx] <= 1'b0;
      dirty_q[idx] <= 1'b0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end else if (clean) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // Payload arrays carry no reset; valid bits gate every use of them.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_data;
    end else if (word_we) begin
      data_q[idx][{word_sel, 5'b0} +: WORD_BITS] <= word_data;
    end
  end

  assign tag   = tag_q[idx];
  assign valid = valid_q[idx];
  assign dirty = dirty_q[idx];
  assign data  = data_q[idx];

endmodule

// File: rtl/dcache_wb.sv
// Write-back, write-allocate set-associative data cache between the MEM
// stage word port and the 256-bit block memory port, with flush support.
module dcache_wb
  import dcache_pkg::*;
#(
  parameter int SETS = 8,
  parameter int WAYS = 2
) (
  input  logic         CLK,
  input  logic         RESET,
  input  logic [31:0]  data_address_2DC,
  input  logic         read_2DC,
  input  logic         write_2DC,
  input  logic [31:0]  data_write_2DC,
  input  logic [1:0]   data_write_size_2DC,
  input  logic         flush_2DC,
  output logic [31:0]  data_read_fDC,
  output logic         data_valid_fDC,
  output logic         flush_done,
  output logic [31:0]  data_address_2DM,
  output logic         dBlkRead,
  output logic         dBlkWrite,
  output logic [255:0] block_write_2DM,
  input  logic [255:0] block_read_fDM,
  input  logic         block_read_fDM_valid,
  input  logic         block_write_fDM_valid
);

  localparam int IDX_BITS = $clog2(SETS);
  localparam int TAG_BITS = 32 - OFFSET_BITS - IDX_BITS;
  localparam int WAY_BITS = (WAYS > 1) ? $clog2(WAYS) : 1;

  logic [2:0]          state_q;
  logic [WAY_BITS-1:0] vic_q;
  logic [WAY_BITS-1:0] scan_way_q;
  logic [IDX_BITS-1:0] scan_set_q;
  logic [WAY_BITS-1:0] rr_q [SETS];

  logic [TAG_BITS-1:0] req_tag;
  logic [IDX_BITS-1:0] req_idx;
  logic [2:0]          req_word;
  logic [IDX_BITS-1:0] idx;
  logic                flushing;

  logic [WAYS-1:0][TAG_BITS-1:0]   way_tag;
  logic [WAYS-1:0][BLOCK_BITS-1:0] way_data;
  logic [WAYS-1:0]                 way_valid;
  logic [WAYS-1:0]                 way_dirty;
  logic [WAYS-1:0]                 word_we, fill_we, clean, inval;

  logic                 hit;
  logic [WAY_BITS-1:0]  hit_way;
  logic [WAY_BITS-1:0]  vic;
  logic [WORD_BITS-1:0] hit_word;
  logic [WORD_BITS-1:0] merged;
  logic                 req;
  logic                 scan_dirty;
  logic                 scan_last;
  logic [WAY_BITS-1:0]  rr_next;

  assign req_tag  = data_address_2DC[31 -: TAG_BITS];
  assign req_idx  = data_address_2DC[OFFSET_BITS +: IDX_BITS];
  assign req_word = data_address_2DC[4:2];
  assign flushing = (state_q == S_FLUSH_SCAN) || (state_q == S_FLUSH_WB);
  assign idx      = flushing ? scan_set_q : req_idx;
  assign req      = read_2DC || write_2DC;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    vic     = rr_q[req_idx];
    // Walking downward lets the lowest-index match/invalid way win.
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (way_valid[w] && way_tag[w] == req_tag) begin
        hit     = 1'b1;
        hit_way = WAY_BITS'(w);
      end
      if (!way_valid[w]) vic = WAY_BITS'(w);
    end
  end

  assign hit_word       = way_data[hit_way][{req_word, 5'b0} +: WORD_BITS];
  assign merged         = byte_merge(hit_word, data_write_size_2DC,
                                     data_address_2DC[1:0], data_write_2DC);
  assign data_valid_fDC = (state_q == S_IDLE) && !flush_2DC && req && hit;
  assign data_read_fDC  = (data_valid_fDC && !write_2DC) ? hit_word : '0;

  assign scan_dirty = way_dirty[scan_way_q];
  assign scan_last  = (scan_set_q == IDX_BITS'(SETS - 1)) &&
                      (scan_way_q == WAY_BITS'(WAYS - 1));
  assign rr_next    = (rr_q[req_idx] == WAY_BITS'(WAYS - 1)) ? '0
                                                             : rr_q[req_idx] + WAY_BITS'(1);

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign word_we[w] = data_valid_fDC && write_2DC && (hit_way == WAY_BITS'(w));
    assign fill_we[w] = (state_q == S_REFILL) && block_read_fDM_valid &&
                        (vic_q == WAY_BITS'(w));
    assign clean[w]   = (state_q == S_WRITEBACK) && block_write_fDM_valid &&
                        (vic_q == WAY_BITS'(w));
    assign inval[w]   = (scan_way_q == WAY_BITS'(w)) &&
                        (((state_q == S_FLUSH_SCAN) && !scan_dirty) ||
                         ((state_q == S_FLUSH_WB) && block_write_fDM_valid));

    dcache_way #(
      .SETS     (SETS),
      .IDX_BITS (IDX_BITS),
      .TAG_BITS (TAG_BITS)
    ) u_way (
      .clk       (CLK),
      .rst_n     (RESET),
      .idx       (idx),
      .word_we   (word_we[w]),
      .word_sel  (req_word),
      .word_data (merged),
      .fill_we   (fill_we[w]),
      .fill_tag  (req_tag),
      .fill_data (block_read_fDM),
      .clean     (clean[w]),
      .inval     (inval[w]),
      .tag       (way_tag[w]),
      .valid     (way_valid[w]),
      .dirty     (way_dirty[w]),
      .data      (way_data[w])
    );
  end

  always_comb begin
    dBlkRead         = (state_q == S_REFILL);
    dBlkWrite        = (state_q == S_WRITEBACK) || (state_q == S_FLUSH_WB);
    flush_done       = (state_q == S_FLUSH_DONE);
    data_address_2DM = '0;
    block_write_2DM  = '0;
    case (state_q)
      S_WRITEBACK: begin
        data_address_2DM = {way_tag[vic_q], req_idx, 5'b0};
        block_write_2DM  = way_data[vic_q];
      end
      S_FLUSH_WB: begin
        data_address_2DM = {way_tag[scan_way_q], scan_set_q, 5'b0};
        block_write_2DM  = way_data[scan_way_q];
      end
      S_REFILL: data_address_2DM = {data_address_2DC[31:5], 5'b0};
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_q    <= S_IDLE;
      vic_q      <= '0;
      scan_set_q <= '0;
      scan_way_q <= '0;
      for (int s = 0; s < SETS; s++) rr_q[s] <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (flush_2DC) begin
            state_q    <= S_FLUSH_SCAN;
            scan_set_q <= '0;
            scan_way_q <= '0;
          end else if (req && !hit) begin
            vic_q   <= vic;
            state_q <= way_dirty[vic] ? S_WRITEBACK : S_REFILL;
          end
        end
        S_WRITEBACK: if (block_write_fDM_valid) state_q <= S_REFILL;
        S_REFILL: begin
          if (block_read_fDM_valid) begin
            rr_q[req_idx] <= rr_next;
            state_q       <= S_IDLE;
          end
        end
        S_FLUSH_SCAN, S_FLUSH_WB: begin
          // A dirty line parks the scan until its write-back is accepted.
          if ((state_q == S_FLUSH_SCAN && !scan_dirty) ||
              (state_q == S_FLUSH_WB && block_write_fDM_valid)) begin
            if (scan_way_q == WAY_BITS'(WAYS - 1)) begin
              scan_way_q <= '0;
              scan_set_q <= scan_set_q + IDX_BITS'(1);
            end else begin
              scan_way_q <= scan_way_q + WAY_BITS'(1);
            end
            state_q <= scan_last ? S_FLUSH_DONE : S_FLUSH_SCAN;
          end else if (state_q == S_FLUSH_SCAN) begin
            state_q <= S_FLUSH_WB;
          end
        end
        S_FLUSH_DONE: state_q <= S_IDLE;
        default:      state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_wb.sv
// Directed bench for dcache_wb (SETS=4, WAYS=2) against a block memory
// that answers three cycles after each request.
module tb_dcache_wb;

  localparam int SETS = 4;
  localparam int WAYS = 2;

  logic         CLK = 1'b0;
  logic         RESET;
  logic [31:0]  data_address_2DC;
  logic         read_2DC, write_2DC, flush_2DC;
  logic [31:0]  data_write_2DC;
  logic [1:0]   data_write_size_2DC;
  logic [31:0]  data_read_fDC;
  logic         data_valid_fDC, flush_done;
  logic [31:0]  data_address_2DM;
  logic         dBlkRead, dBlkWrite;
  logic [255:0] block_write_2DM, block_read_fDM;
  logic         block_read_fDM_valid, block_write_fDM_valid;

  always #5 CLK = ~CLK;

  dcache_wb #(.SETS(SETS), .WAYS(WAYS)) dut (
    .CLK                   (CLK),
    .RESET                 (RESET),
    .data_address_2DC      (data_address_2DC),
    .read_2DC              (read_2DC),
    .write_2DC             (write_2DC),
    .data_write_2DC        (data_write_2DC),
    .data_write_size_2DC   (data_write_size_2DC),
    .flush_2DC             (flush_2DC),
    .data_read_fDC         (data_read_fDC),
    .data_valid_fDC        (data_valid_fDC),
    .flush_done            (flush_done),
    .data_address_2DM      (data_address_2DM),
    .dBlkRead              (dBlkRead),
    .dBlkWrite             (dBlkWrite),
    .block_write_2DM       (block_write_2DM),
    .block_read_fDM        (block_read_fDM),
    .block_read_fDM_valid  (block_read_fDM_valid),
    .block_write_fDM_valid (block_write_fDM_valid)
  );

  int checks = 0;
  int errors = 0;
  int excl_viol = 0;

  logic [255:0] mem [int];
  logic [32:0]  ev_q [$];       // {is_writeback, block address}
  logic [31:0]  wb_word1_q [$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Untouched memory holds each word's own byte address.
  function automatic logic [255:0] blk_default(input logic [31:0] a);
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = a + 32'(4*i);
    return r;
  endfunction

  initial begin
    int cnt;
    logic [255:0] b;
    cnt = 0;
    block_read_fDM_valid  = 1'b0;
    block_write_fDM_valid = 1'b0;
    block_read_fDM        = '0;
    b = blk_default(32'h1000);
    b[63:32] = 32'hDEADBEEF;
    mem[32'h1000] = b;
    forever begin
      @(negedge CLK);
      block_read_fDM_valid  = 1'b0;
      block_write_fDM_valid = 1'b0;
      if (RESET && dBlkRead) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          block_read_fDM = mem.exists(int'(data_address_2DM)) ? mem[int'(data_address_2DM)]
                                                              : blk_default(data_address_2DM);
          block_read_fDM_valid = 1'b1;
          ev_q.push_back({1'b0, data_address_2DM});
        end
      end else if (RESET && dBlkWrite) begin
        cnt++;
        if (cnt == 3) begin
          cnt = 0;
          mem[int'(data_address_2DM)] = block_write_2DM;
          block_write_fDM_valid = 1'b1;
          ev_q.push_back({1'b1, data_address_2DM});
          wb_word1_q.push_back(block_write_2DM[63:32]);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  always @(negedge CLK) if (dBlkRead && dBlkWrite) excl_viol++;

  task automatic do_access(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] wd,
                           output logic ok, output logic [31:0] rdat, output int lat);
    read_2DC = rd; write_2DC = wr; data_address_2DC = a;
    data_write_size_2DC = sz; data_write_2DC = wd;
    ok = 1'b0; rdat = '0; lat = 0;
    for (int k = 0; k < 200; k++) begin
      #1;
      if (data_valid_fDC) begin
        ok = 1'b1;
        rdat = data_read_fDC;
        break;
      end
      @(negedge CLK);
      lat++;
    end
    @(posedge CLK);
    @(negedge CLK);
    read_2DC = 1'b0; write_2DC = 1'b0;
  endtask

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_miss;
    int          exp_nev;
    logic [32:0] exp_ev0;
    logic [32:0] exp_ev1;
  } vec_t;

  function automatic vec_t mk(input logic rd, input logic wr, input logic [31:0] a,
                              input logic [1:0] sz, input logic [31:0] wd,
                              input logic [31:0] er, input logic em, input int ne,
                              input logic [32:0] e0, input logic [32:0] e1);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.size = sz; v.wdata = wd;
    v.exp_rdata = er; v.exp_miss = em; v.exp_nev = ne; v.exp_ev0 = e0; v.exp_ev1 = e1;
    return v;
  endfunction

  localparam logic [32:0] R = 33'h0_0000_0000;
  localparam logic [32:0] W = 33'h1_0000_0000;

  vec_t vecs [20];

  initial begin
    logic        ok;
    logic [31:0] rdat;
    int          lat, n0, fd, early, kdone;
    logic        got, seen;

    vecs[0]  = mk(1, 0, 32'h1004, 0, 0,             32'hDEADBEEF, 1, 1, R | 33'h1000, 0);
    vecs[1]  = mk(0, 1, 32'h1005, 1, 32'h000000AB,  0,            0, 0, 0, 0);
    vecs[2]  = mk(1, 0, 32'h1004, 0, 0,             32'hDEABBEEF, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 32'h1006, 2, 32'h00001234,  0,            0, 0, 0, 0);
    vecs[4]  = mk(1, 0, 32'h1004, 0, 0,             32'hDEAB1234, 0, 0, 0, 0);
    vecs[5]  = mk(1, 0, 32'h1080, 0, 0,             32'h00001080, 1, 1, R | 33'h1080, 0);
    vecs[6]  = mk(1, 0, 32'h1100, 0, 0,             32'h00001100, 1, 2, W | 33'h1000, R | 33'h1100);
    vecs[7]  = mk(1, 0, 32'h1084, 0, 0,             32'h00001084, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 32'h1000, 0, 0,             32'h00001000, 1, 1, R | 33'h1000, 0);
    vecs[9]  = mk(1, 0, 32'h1004, 0, 0,             32'hDEAB1234, 0, 0, 0, 0);
    vecs[10] = mk(0, 1, 32'h1003, 0, 32'hCAFEF00D,  0,            0, 0, 0, 0);
    vecs[11] = mk(1, 0, 32'h1000, 0, 0,             32'h000010CA, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 32'h1001, 3, 32'h00A1B2C3,  0,            0, 0, 0, 0);
    vecs[13] = mk(1, 0, 32'h1000, 0, 0,             32'h00A1B2C3, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 32'h2020, 0, 32'h11223344,  0,            1, 1, R | 33'h2020, 0);
    vecs[15] = mk(1, 0, 32'h2020, 0, 0,             32'h11223344, 0, 0, 0, 0);
    vecs[16] = mk(1, 1, 32'h2024, 0, 32'h55667788,  0,            0, 0, 0, 0);
    vecs[17] = mk(1, 0, 32'h2024, 0, 0,             32'h55667788, 0, 0, 0, 0);
    vecs[18] = mk(1, 0, 32'h1100, 0, 0,             32'h00001100, 0, 0, 0, 0);
    vecs[19] = mk(1, 0, 32'h1080, 0, 0,             32'h00001080, 1, 1, R | 33'h1080, 0);

    RESET = 1'b0;
    read_2DC = 0; write_2DC = 0; flush_2DC = 0;
    data_address_2DC = 0; data_write_2DC = 0; data_write_size_2DC = 0;
    repeat (2) @(negedge CLK);
    #1;
    chk("rst_dBlkRead", dBlkRead, 0);
    chk("rst_dBlkWrite", dBlkWrite, 0);
    chk("rst_data_valid", data_valid_fDC, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_addr_2DM", data_address_2DM, 0);
    chk("rst_data_read", data_read_fDC, 0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 20; i++) begin
      n0 = ev_q.size();
      do_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].size, vecs[i].wdata, ok, rdat, lat);
      chk($sformatf("v%0d_valid", i), ok, 1);
      chk($sformatf("v%0d_miss", i), lat != 0, vecs[i].exp_miss);
      if (vecs[i].rd && !vecs[i].wr) chk($sformatf("v%0d_rdata", i), rdat, vecs[i].exp_rdata);
      chk($sformatf("v%0d_nev", i), ev_q.size() - n0, vecs[i].exp_nev);
      if (vecs[i].exp_nev > 0 && ev_q.size() > n0)
        chk($sformatf("v%0d_ev0", i), ev_q[n0], vecs[i].exp_ev0);
      if (vecs[i].exp_nev > 1 && ev_q.size() > n0 + 1)
        chk($sformatf("v%0d_ev1", i), ev_q[n0+1], vecs[i].exp_ev1);
    end
    chk("evict_wb_count", wb_word1_q.size(), 1);
    if (wb_word1_q.size() > 0) chk("evict_wb_word1", wb_word1_q[0], 32'hDEAB1234);

    // Flush with read pending: two dirty lines (0x1000 set0, 0x2020 set1).
    n0 = ev_q.size(); fd = 0; early = 0; got = 0; rdat = 0;
    flush_2DC = 1; read_2DC = 1; data_address_2DC = 32'h1004;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge CLK);
      #1;
      if (flush_done) begin fd++; flush_2DC = 0; end
      if (data_valid_fDC) begin
        if (fd == 0) early++;
        got = 1;
        rdat = data_read_fDC;
      end
    end
    @(posedge CLK);
    @(negedge CLK);
    read_2DC = 0; flush_2DC = 0;
    chk("flush_done_pulses", fd, 1);
    chk("flush_read_done", got, 1);
    chk("flush_read_before_done", early, 0);
    chk("flush_read_data", rdat, 32'hDEAB1234);
    chk("flush_nev", ev_q.size() - n0, 3);
    if (ev_q.size() >= n0 + 3) begin
      chk("flush_ev0", ev_q[n0], W | 33'h1000);
      chk("flush_ev1", ev_q[n0+1], W | 33'h2020);
      chk("flush_ev2", ev_q[n0+2], R | 33'h1000);
    end
    if (wb_word1_q.size() >= 3) begin
      chk("flush_wb1_word1", wb_word1_q[1], 32'hDEAB1234);
      chk("flush_wb2_word1", wb_word1_q[2], 32'h55667788);
    end

    // Flush with no dirty lines: SETS*WAYS+1 cycles, no memory traffic.
    n0 = ev_q.size(); kdone = 0;
    flush_2DC = 1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge CLK);
      #1;
      if (flush_done) begin kdone = k; break; end
    end
    flush_2DC = 0;
    @(negedge CLK);
    chk("clean_flush_cycles", kdone, SETS * WAYS + 1);
    chk("clean_flush_nev", ev_q.size() - n0, 0);
    n0 = ev_q.size();
    do_access(1, 0, 32'h1004, 0, 0, ok, rdat, lat);
    chk("post_flush_miss", lat != 0, 1);
    chk("post_flush_data", rdat, 32'hDEAB1234);
    chk("post_flush_ev", (ev_q.size() > n0) ? ev_q[n0] : 33'h0, R | 33'h1000);

    // Reset while a refill is outstanding.
    read_2DC = 1; data_address_2DC = 32'h1040; seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge CLK);
      #1;
      if (dBlkRead) begin seen = 1; break; end
    end
    chk("refill_started", seen, 1);
    #2 RESET = 0;
    #1;
    chk("async_dBlkRead", dBlkRead, 0);
    chk("async_addr_2DM", data_address_2DM, 0);
    @(negedge CLK);
    read_2DC = 0;
    RESET = 1;
    n0 = ev_q.size();
    do_access(1, 0, 32'h1000, 0, 0, ok, rdat, lat);
    chk("post_reset_miss", lat != 0, 1);
    chk("post_reset_data", rdat, 32'h00A1B2C3);
    chk("post_reset_nev", ev_q.size() - n0, 1);

    chk("rd_wr_exclusive", excl_viol, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
